ibis_dvi_sequencer: RTL and testbench



---
 rtl/ibis_dvi_pkg.sv | 16 +
 rtl/ibis_sync_2ff.sv | 21 ++
 rtl/ibis_dvi_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ibis_dvi_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibis_dvi_pkg.sv
// Shared encodings for the Ibis DVI link sequencer: FSM states and video source selects.
package ibis_dvi_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WARMUP    = 3'd2,
    ST_BLANK     = 3'd3,
    ST_ACTIVE    = 3'd4,
    ST_DRAIN     = 3'd5
  } state_t;

  localparam logic SRC_PATTERN = 1'b0;
  localparam logic SRC_FB      = 1'b1;

endpackage

// File: rtl/ibis_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status bit; output lags input by 2 edges.
module ibis_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/ibis_dvi_sequencer.sv
// DVI link bring-up sequencer: PLL lock -> TMDS warm-up -> blanked frames -> live video.
// Moore outputs follow the state register one edge after the sampled condition.
module ibis_dvi_sequencer
  import ibis_dvi_pkg::*;
#(
  parameter int WARMUP_CYCLES = 1024,
  parameter int BLANK_FRAMES  = 2
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       pll_locked,
  input  logic       link_up_req,
  input  logic       src_req,
  input  logic       frame_start,
  output logic       timing_enable,
  output logic       tmds_enable,
  output logic       video_mute,
  output logic       src_sel,
  output logic       link_active,
  output logic [2:0] state,
  output logic       lock_lost,
  output logic [7:0] drop_count
);

  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int FW = $clog2(BLANK_FRAMES + 1);
  localparam logic [WW-1:0] WARM_LOAD  = WW'(WARMUP_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_DONE = FW'(BLANK_FRAMES);

  logic          lock_s;
  logic [2:0]    state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [FW-1:0] frame_q, frame_d, frame_inc;
  logic          src_q, src_d;
  logic          lost_q, lost_d;
  logic [7:0]    drop_q, drop_d;
  logic          abort;

  ibis_sync_2ff u_lock_sync (
    .clk  (aclk),
    .rst  (areset),
    .din  (pll_locked),
    .dout (lock_s)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_OFF;
      warm_q  <= '0;
      frame_q <= '0;
      src_q   <= SRC_PATTERN;
      lost_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      frame_q <= frame_d;
      src_q   <= src_d;
      lost_q  <= lost_d;
      drop_q  <= drop_d;
    end
  end

  assign frame_inc = frame_q + 1'b1;
  // Lock loss outranks every other transition condition in the powered states.
  assign abort = !lock_s && (state_q inside {ST_WARMUP, ST_BLANK, ST_ACTIVE, ST_DRAIN});

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    frame_d = frame_q;
    src_d   = src_q;
    lost_d  = 1'b0;
    drop_d  = drop_q;
    if (abort) begin
      state_d = ST_WAIT_LOCK;
      warm_d  = '0;
      frame_d = '0;
      lost_d  = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (link_up_req) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (!link_up_req) begin
            state_d = ST_OFF;
          end else if (lock_s) begin
            state_d = ST_WARMUP;
            warm_d  = WARM_LOAD;
          end
        end
        ST_WARMUP: begin
          if (!link_up_req) begin
            state_d = ST_OFF;
            warm_d  = '0;
          end else if (warm_q == '0) begin
            state_d = ST_BLANK;
            frame_d = '0;
          end else begin
            warm_d = warm_q - 1'b1;
          end
        end
        ST_BLANK: begin
          if (!link_up_req) begin
            state_d = ST_OFF;
            frame_d = '0;
          end else if (frame_start) begin
            frame_d = frame_inc;
            if (frame_inc == FRAME_DONE) begin
              state_d = ST_ACTIVE;
              src_d   = src_req;
            end
          end
        end
        ST_ACTIVE: begin
          if (frame_start) src_d = src_req;
          if (!link_up_req) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (frame_start) begin
            state_d = ST_OFF;
            frame_d = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
          warm_d  = '0;
          frame_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    timing_enable = 1'b0;
    tmds_enable   = 1'b0;
    video_mute    = 1'b1;
    link_active   = 1'b0;
    case (state_q)
      ST_WARMUP: tmds_enable = 1'b1;
      ST_BLANK, ST_DRAIN: begin
        tmds_enable   = 1'b1;
        timing_enable = 1'b1;
      end
      ST_ACTIVE: begin
        tmds_enable   = 1'b1;
        timing_enable = 1'b1;
        video_mute    = 1'b0;
        link_active   = 1'b1;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign src_sel    = src_q;
  assign lock_lost  = lost_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_ibis_dvi_sequencer.sv
// Bench for ibis_dvi_sequencer: reference-model scoreboard plus directed bring-up checks.
module tb_ibis_dvi_sequencer;

  localparam int WARM   = 16;
  localparam int FRAMES = 2;

  logic       aclk = 1'b0;
  logic       areset, pll_locked, link_up_req, src_req, frame_start;
  logic       timing_enable, tmds_enable, video_mute, src_sel, link_active, lock_lost;
  logic [2:0] state;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ibis_dvi_sequencer #(.WARMUP_CYCLES(WARM), .BLANK_FRAMES(FRAMES)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .pll_locked    (pll_locked),
    .link_up_req   (link_up_req),
    .src_req       (src_req),
    .frame_start   (frame_start),
    .timing_enable (timing_enable),
    .tmds_enable   (tmds_enable),
    .video_mute    (video_mute),
    .src_sel       (src_sel),
    .link_active   (link_active),
    .state         (state),
    .lock_lost     (lock_lost),
    .drop_count    (drop_count)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [2:0] st;
    logic       timing;
    logic       tmds;
    logic       mute;
    logic       src;
    logic       active;
    logic       lost;
    logic [7:0] drops;
  } obs_t;

  obs_t sb[$];

  // Reference model: phase 0..5 = off, wait-lock, warm-up, blank, active, drain.
  int m_phase = 0, m_warm_left = 0, m_frames = 0, m_drops = 0;
  bit m_src = 0, m_lost = 0, m_s1 = 0, m_ls = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.st     = 3'(m_phase);
    o.tmds   = (m_phase >= 2);
    o.timing = (m_phase >= 3);
    o.mute   = (m_phase != 4);
    o.active = (m_phase == 4);
    o.src    = m_src;
    o.lost   = m_lost;
    o.drops  = 8'(m_drops);
    return o;
  endfunction

  always @(posedge aclk) begin
    cyc++;
    if (areset) begin
      m_phase = 0; m_warm_left = 0; m_frames = 0; m_drops = 0;
      m_src = 0; m_lost = 0; m_s1 = 0; m_ls = 0;
    end else begin
      m_lost = 0;
      if (!m_ls && m_phase >= 2) begin
        m_phase = 1;
        m_lost  = 1;
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end else begin
        case (m_phase)
          0: if (link_up_req) m_phase = 1;
          1: if (!link_up_req) m_phase = 0;
             else if (m_ls) begin m_phase = 2; m_warm_left = WARM; end
          2: if (!link_up_req) m_phase = 0;
             else begin
               m_warm_left--;
               if (m_warm_left == 0) begin m_phase = 3; m_frames = 0; end
             end
          3: if (!link_up_req) m_phase = 0;
             else if (frame_start) begin
               m_frames++;
               if (m_frames == FRAMES) begin m_phase = 4; m_src = src_req; end
             end
          4: begin
               if (frame_start) m_src = src_req;
               if (!link_up_req) m_phase = 5;
             end
          5: if (frame_start) m_phase = 0;
          default: m_phase = 0;
        endcase
      end
      m_ls = m_s1;
      m_s1 = pll_locked;
    end
    sb.push_back(model_obs());
  end

  always @(negedge aclk) begin
    obs_t exp_o, act_o;
    if (sb.size() > 0) begin
      exp_o = sb.pop_front();
      act_o = '{state, timing_enable, tmds_enable, video_mute, src_sel, link_active, lock_lost, drop_count};
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL scoreboard cycle %0d: got st=%0d tim=%b tmds=%b mute=%b src=%b act=%b lost=%b drops=%0d, need st=%0d tim=%b tmds=%b mute=%b src=%b act=%b lost=%b drops=%0d",
                 cyc, act_o.st, act_o.timing, act_o.tmds, act_o.mute, act_o.src, act_o.active, act_o.lost, act_o.drops,
                 exp_o.st, exp_o.timing, exp_o.tmds, exp_o.mute, exp_o.src, exp_o.active, exp_o.lost, exp_o.drops);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d", name, act, req);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    areset = 1'b1; pll_locked = 1'b1; link_up_req = 1'b0; src_req = 1'b0; frame_start = 1'b0;
    tick(3);
    check("reset state", int'(state), 0);
    check("reset mute", int'(video_mute), 1);
    check("reset tmds", int'(tmds_enable), 0);
    areset = 1'b0;
    tick(4);

    // Startup with lock already synchronised
    link_up_req = 1'b1;
    tick(1);
    check("wait_lock at edge 1", int'(state), 1);
    tick(1);
    check("tmds_enable at edge 2", int'(tmds_enable), 1);
    check("timing off in warmup", int'(timing_enable), 0);
    tick(WARM - 1);
    check("still warmup at edge 17", int'(timing_enable), 0);
    tick(1);
    check("timing_enable at edge 18", int'(timing_enable), 1);
    check("blank state", int'(state), 3);
    tick(5);
    pulse_frame();
    check("muted after frame 1", int'(video_mute), 1);
    tick(7);
    pulse_frame();
    check("link_active after frame 2", int'(link_active), 1);
    check("unmuted in active", int'(video_mute), 0);
    check("src latched at entry", int'(src_sel), 0);

    // Mid-frame source change waits for the frame boundary
    tick(3);
    src_req = 1'b1;
    tick(6);
    check("src held mid-frame", int'(src_sel), 0);
    pulse_frame();
    check("src follows frame_start", int'(src_sel), 1);

    // Teardown through DRAIN
    tick(2);
    link_up_req = 1'b0;
    tick(1);
    check("drain entered", int'(state), 5);
    check("drain mute", int'(video_mute), 1);
    tick(5);
    check("drain holds", int'(state), 5);
    pulse_frame();
    check("off after drain", int'(state), 0);
    check("off tmds", int'(tmds_enable), 0);
    check("off timing", int'(timing_enable), 0);

    // Lock loss in ACTIVE
    link_up_req = 1'b1;
    tick(2 + WARM);
    check("blank again", int'(state), 3);
    pulse_frame();
    tick(3);
    pulse_frame();
    check("active again", int'(state), 4);
    pll_locked = 1'b0;
    tick(2);
    check("active before lock_s drops", int'(state), 4);
    tick(1);
    check("wait_lock after lock loss", int'(state), 1);
    check("lock_lost pulse", int'(lock_lost), 1);
    check("drop_count one", int'(drop_count), 1);
    tick(1);
    check("lock_lost single", int'(lock_lost), 0);
    pll_locked = 1'b1;
    tick(3);
    check("warmup rerun", int'(state), 2);
    tick(WARM);
    check("blank rerun", int'(state), 3);

    // Lock loss coincident with frame_start in BLANK
    pll_locked = 1'b0;
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("collision to wait_lock", int'(state), 1);
    check("drop_count two", int'(drop_count), 2);

    // Reset asserted in BLANK
    pll_locked = 1'b1;
    tick(3 + WARM);
    check("blank before reset", int'(state), 3);
    areset = 1'b1;
    tick(1);
    check("reset state in blank", int'(state), 0);
    check("reset tmds in blank", int'(tmds_enable), 0);
    check("reset timing in blank", int'(timing_enable), 0);
    check("reset src in blank", int'(src_sel), 0);
    check("reset drops in blank", int'(drop_count), 0);
    areset = 1'b0;

    // Drop counter saturation
    link_up_req = 1'b1;
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b1;
      tick(6);
      pll_locked = 1'b0;
      tick(4);
    end
    check("drop_count saturates", int'(drop_count), 255);

    // Randomised traffic
    pll_locked = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      areset      = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 79) == 0)  link_up_req = ~link_up_req;
      if ($urandom_range(0, 149) == 0) pll_locked  = ~pll_locked;
      if ($urandom_range(0, 9) == 0)   src_req     = ~src_req;
      frame_start = ($urandom_range(0, 11) == 0);
      tick(1);
    end
    areset = 1'b0; frame_start = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
